// File: rtl/sd_port_arbiter.sv
// Shares one MiSTer SD block port between the SDC hard-disk controller (0) and the floppy
// controller (1): round-robin grant, one sector per grant, ack/transfer timeout.
module sd_port_arbiter #(
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic        clock,
    input  logic        RESET_N,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [31:0] req_lba0,
    input  logic [31:0] req_lba1,
    input  logic [7:0]  req_buff_din0,
    input  logic [7:0]  req_buff_din1,
    output logic [1:0]  req_ack,
    output logic [1:0]  req_buff_wr,
    output logic [1:0]  req_done,
    output logic [1:0]  req_err,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StXfer,
        StDone,
        StErr,
        StRelease
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic                   op_wr_q, op_wr_d;
    logic [31:0]            sd_lba_q, sd_lba_d;
    logic                   sd_rd_q, sd_rd_d;
    logic                   sd_wr_q, sd_wr_d;
    logic [1:0]             req_done_q, req_done_d;
    logic [1:0]             req_err_q, req_err_d;
    logic                   busy_q, busy_d;
    logic                   ack_prev_q;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;

    logic [1:0]             pending;
    logic                   owner;
    logic                   sel;
    logic [TIMEOUT_W-1:0]   timer_inc;

    assign pending   = req_rd | req_wr;
    assign owner     = grant_q[1];
    assign timer_inc = (&timer_q) ? timer_q : timer_q + TIMEOUT_W'(1);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        op_wr_d      = op_wr_q;
        sd_lba_d     = sd_lba_q;
        sd_rd_d      = sd_rd_q;
        sd_wr_d      = sd_wr_q;
        req_done_d   = 2'b00;
        req_err_d    = 2'b00;
        timer_d      = timer_q;
        sel          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pending != 2'b00) begin
                    sel      = (pending == 2'b11) ? ~last_grant_q : pending[1];
                    grant_d  = sel ? 2'b10 : 2'b01;
                    // rd wins when both are asserted
                    op_wr_d  = ~req_rd[sel] & req_wr[sel];
                    sd_lba_d = sel ? req_lba1 : req_lba0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                sd_rd_d = ~op_wr_q;
                sd_wr_d = op_wr_q;
                timer_d = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (sd_ack) begin
                    sd_rd_d = 1'b0;
                    sd_wr_d = 1'b0;
                    timer_d = '0;
                    state_d = StXfer;
                end else begin
                    timer_d = timer_inc;
                    if (&timer_inc) begin
                        sd_rd_d = 1'b0;
                        sd_wr_d = 1'b0;
                        state_d = StErr;
                    end
                end
            end
            StXfer: begin
                if (ack_prev_q && !sd_ack) begin
                    state_d = StDone;
                end else begin
                    timer_d = timer_inc;
                    if (&timer_inc) state_d = StErr;
                end
            end
            StDone: begin
                req_done_d   = grant_q;
                last_grant_d = owner;
                state_d      = StRelease;
            end
            StErr: begin
                sd_rd_d      = 1'b0;
                sd_wr_d      = 1'b0;
                req_err_d    = grant_q;
                last_grant_d = owner;
                state_d      = StRelease;
            end
            StRelease: begin
                // wait for the owner to let go so a held request is not re-issued
                if (!req_rd[owner] && !req_wr[owner]) begin
                    grant_d = 2'b00;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(negedge clock or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= StIdle;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            op_wr_q      <= 1'b0;
            sd_lba_q     <= '0;
            sd_rd_q      <= 1'b0;
            sd_wr_q      <= 1'b0;
            req_done_q   <= 2'b00;
            req_err_q    <= 2'b00;
            busy_q       <= 1'b0;
            ack_prev_q   <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            op_wr_q      <= op_wr_d;
            sd_lba_q     <= sd_lba_d;
            sd_rd_q      <= sd_rd_d;
            sd_wr_q      <= sd_wr_d;
            req_done_q   <= req_done_d;
            req_err_q    <= req_err_d;
            busy_q       <= busy_d;
            ack_prev_q   <= sd_ack;
            timer_q      <= timer_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign sd_lba      = sd_lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign req_done    = req_done_q;
    assign req_err     = req_err_q;
    assign req_ack     = {2{sd_ack}} & grant_q;
    assign req_buff_wr = {2{sd_buff_wr & sd_ack}} & grant_q;
    assign sd_buff_din = grant_q[1] ? req_buff_din1 : req_buff_din0;

endmodule
